// File: rtl/limb_pkg.sv
// Shared definitions for the load/store unit.
// FSM encoding plus lane and word geometry.
package limb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_WRITE,
      ST_RESP
   } lsu_state_t;

   localparam int LANE_W     = 8;
   localparam int LANE_SHIFT = 3;
   localparam int WORD_SHIFT = 2;

   localparam logic [31:0] LANE_MASK = 32'((1 << LANE_W) - 1);

   function automatic logic [4:0] lane_bit_ofs(input logic [1:0] lane);
      return 5'(lane) << LANE_SHIFT;
   endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian byte lane extract (for loads) and merge (for stores).
// Purely combinational.
module byte_lane_unit
   import limb_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_extract,
   output logic [31:0] o_merge
);

   logic [4:0]  w_shift;
   logic [31:0] w_mask;

   assign w_shift   = lane_bit_ofs(i_lane);
   assign w_mask    = LANE_MASK << w_shift;
   assign o_extract = (i_word >> w_shift) & LANE_MASK;
   assign o_merge   = (i_word & ~w_mask) | (32'(i_byte) << w_shift);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a synchronous RAM.
// Byte stores are done as read-modify-write of the containing word.
module load_store_unit
   import limb_pkg::*;
#(
   parameter int MEM_WORDS = 8192
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic        req_byte,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_rd,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [3:0]  rsp_rd,
   output logic        rsp_fault,
   output logic [31:0] ram_a,
   output logic [31:0] ram_din,
   output logic        ram_rw,
   input  logic [31:0] ram_dout
);

   lsu_state_t  r_state;
   logic        r_load;
   logic        r_byte;
   logic [1:0]  r_lane;
   logic [7:0]  r_wbyte;
   logic [3:0]  r_rd;

   logic [31:0] w_idx;
   logic        w_fault;
   logic [31:0] w_extract;
   logic [31:0] w_merge;

   assign w_idx   = req_addr >> WORD_SHIFT;
   assign w_fault = (!req_byte && (req_addr[1:0] != 2'b00))
                  || (w_idx >= 32'(MEM_WORDS));

   byte_lane_unit u_lane (
      .i_word    (ram_dout),
      .i_lane    (r_lane),
      .i_byte    (r_wbyte),
      .o_extract (w_extract),
      .o_merge   (w_merge)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_load    <= 1'b0;
         r_byte    <= 1'b0;
         r_lane    <= 2'b00;
         r_wbyte   <= 8'h00;
         r_rd      <= 4'h0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_rd    <= 4'h0;
         rsp_fault <= 1'b0;
         ram_a     <= 32'h0;
         ram_din   <= 32'h0;
         ram_rw    <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_load    <= req_load;
                  r_byte    <= req_byte;
                  r_lane    <= req_addr[1:0];
                  r_wbyte   <= req_wdata[7:0];
                  r_rd      <= req_rd;
                  req_ready <= 1'b0;
                  if (w_fault) begin
                     r_state   <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_fault <= 1'b1;
                     rsp_rdata <= 32'h0;
                     rsp_rd    <= req_rd;
                  end else if (req_load || req_byte) begin
                     r_state <= ST_READ;
                     ram_a   <= w_idx;
                  end else begin
                     r_state <= ST_WRITE;
                     ram_a   <= w_idx;
                     ram_din <= req_wdata;
                     ram_rw  <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // ram_dout now holds the word addressed in READ
               if (r_load) begin
                  r_state   <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_fault <= 1'b0;
                  rsp_rdata <= r_byte ? w_extract : ram_dout;
                  rsp_rd    <= r_rd;
               end else begin
                  r_state <= ST_WRITE;
                  ram_din <= w_merge;
                  ram_rw  <= 1'b1;
               end
            end
            ST_WRITE: begin
               r_state   <= ST_RESP;
               ram_rw    <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_fault <= 1'b0;
               rsp_rdata <= 32'h0;
               rsp_rd    <= r_rd;
            end
            ST_RESP: begin
               r_state   <= ST_IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               r_state   <= ST_IDLE;
               rsp_valid <= 1'b0;
               ram_rw    <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural synchronous RAM.
// Checks data, tags, faults, latency and write-strobe counts.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_load;
   logic        req_byte;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_rd;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [3:0]  rsp_rd;
   logic        rsp_fault;
   logic [31:0] ram_a;
   logic [31:0] ram_din;
   logic        ram_rw;
   logic [31:0] ram_dout;

   logic [31:0] mem [0:8191];

   int n_cmp = 0;
   int n_err = 0;
   int rw_cnt = 0;
   int rv_cnt = 0;

   int          lat;
   logic [31:0] g_rdata;
   logic [3:0]  g_rd;
   logic        g_fault;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(8192)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_load  (req_load),
      .req_byte  (req_byte),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_rd    (req_rd),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_rd    (rsp_rd),
      .rsp_fault (rsp_fault),
      .ram_a     (ram_a),
      .ram_din   (ram_din),
      .ram_rw    (ram_rw),
      .ram_dout  (ram_dout)
   );

   always @(posedge clk) begin
      if (ram_rw === 1'b1)
         mem[ram_a[12:0]] <= ram_din;
      ram_dout <= mem[ram_a[12:0]];
   end

   always @(negedge clk) begin
      if (ram_rw === 1'b1) rw_cnt++;
      if (rsp_valid === 1'b1) rv_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic ld, input logic by,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] rd);
      int k;
      k = 0;
      while (req_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      req_valid = 1'b1;
      req_load  = ld;
      req_byte  = by;
      req_addr  = a;
      req_wdata = wd;
      req_rd    = rd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_load  = ~ld;
      req_byte  = ~by;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h0;
      req_rd    = 4'hF;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            lat     = i;
            g_rdata = rsp_rdata;
            g_rd    = rsp_rd;
            g_fault = rsp_fault;
            break;
         end
      end
   endtask

   int rw0;
   int rv0;
   int n_acc;
   int j;
   logic [3:0] tags[$];

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req_load  = 1'b0;
      req_byte  = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      req_rd    = 4'h0;
      for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_rd", 32'(rsp_rd), 32'd0);
      chk("rst_fault", 32'(rsp_fault), 32'd0);
      chk("rst_ram_rw", 32'(ram_rw), 32'd0);
      chk("rst_ram_a", ram_a, 32'h0);
      chk("rst_ram_din", ram_din, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      mem[4] = 32'hDEADBEEF;
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'd3);
      chk("wload_lat", 32'(lat), 32'd2);
      chk("wload_data", g_rdata, 32'hDEADBEEF);
      chk("wload_rd", 32'(g_rd), 32'd3);
      chk("wload_fault", 32'(g_fault), 32'd0);

      mem[2] = 32'h11223344;
      rw0 = rw_cnt;
      do_req(1'b0, 1'b1, 32'h09, 32'h0000_00AB, 4'd5);
      chk("bstore_lat", 32'(lat), 32'd3);
      chk("bstore_mem", mem[2], 32'h1122AB44);
      chk("bstore_rw_pulses", 32'(rw_cnt - rw0), 32'd1);
      chk("bstore_rdata", g_rdata, 32'h0);
      chk("bstore_rd", 32'(g_rd), 32'd5);

      do_req(1'b1, 1'b1, 32'h0B, 32'h0, 4'd7);
      chk("bload3_lat", 32'(lat), 32'd2);
      chk("bload3_data", g_rdata, 32'h00000011);
      chk("bload3_rd", 32'(g_rd), 32'd7);
      do_req(1'b1, 1'b1, 32'h08, 32'h0, 4'd1);
      chk("bload0_data", g_rdata, 32'h00000044);
      do_req(1'b1, 1'b1, 32'h09, 32'h0, 4'd2);
      chk("bload1_data", g_rdata, 32'h000000AB);

      rw0 = rw_cnt;
      do_req(1'b1, 1'b0, 32'h06, 32'h0, 4'd4);
      chk("misal_lat", 32'(lat), 32'd0);
      chk("misal_fault", 32'(g_fault), 32'd1);
      chk("misal_rdata", g_rdata, 32'h0);
      chk("misal_rd", 32'(g_rd), 32'd4);
      do_req(1'b0, 1'b0, 32'h8000, 32'h1234, 4'd6);
      chk("range_lat", 32'(lat), 32'd0);
      chk("range_fault", 32'(g_fault), 32'd1);
      chk("range_rdata", g_rdata, 32'h0);
      @(negedge clk);
      chk("fault_no_rw", 32'(rw_cnt - rw0), 32'd0);

      do_req(1'b0, 1'b0, 32'h7FFC, 32'h600D_CAFE, 4'd8);
      chk("top_store_lat", 32'(lat), 32'd1);
      chk("top_store_fault", 32'(g_fault), 32'd0);
      chk("top_store_mem", mem[8191], 32'h600D_CAFE);
      do_req(1'b0, 1'b0, 32'h40, 32'hCAFEF00D, 4'd9);
      chk("wstore_lat", 32'(lat), 32'd1);
      chk("wstore_mem", mem[16], 32'hCAFEF00D);
      chk("wstore_rd", 32'(g_rd), 32'd9);

      // Reset while a load sits in WAIT
      @(negedge clk);
      @(negedge clk);
      rw0 = rw_cnt;
      rv0 = rv_cnt;
      req_valid = 1'b1;
      req_load  = 1'b1;
      req_byte  = 1'b0;
      req_addr  = 32'h10;
      req_rd    = 4'd11;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      repeat (5) @(negedge clk);
      chk("mid_rst_no_rsp", 32'(rv_cnt - rv0), 32'd0);
      chk("mid_rst_no_rw", 32'(rw_cnt - rw0), 32'd0);
      do_req(1'b0, 1'b0, 32'h0, 32'h5, 4'd12);
      chk("post_rst_lat", 32'(lat), 32'd1);
      chk("post_rst_mem", mem[0], 32'h5);
      chk("post_rst_rd", 32'(g_rd), 32'd12);

      // req_valid held high across back-to-back word stores
      repeat (2) @(negedge clk);
      rw0 = rw_cnt;
      n_acc = 0;
      j = 0;
      req_valid = 1'b1;
      req_load  = 1'b0;
      req_byte  = 1'b0;
      for (int c = 0; c < 14; c++) begin
         if (rsp_valid === 1'b1) tags.push_back(rsp_rd);
         if (c == 10) req_valid = 1'b0;
         if (c < 10) begin
            req_addr  = 32'h100 + 32'(j * 4);
            req_wdata = 32'hA000 + 32'(j);
            req_rd    = 4'(j + 1);
            if (req_ready === 1'b1) begin
               n_acc++;
               j++;
            end
         end
         @(negedge clk);
      end
      chk("b2b_accepts", 32'(n_acc), 32'd4);
      chk("b2b_rw_pulses", 32'(rw_cnt - rw0), 32'd4);
      chk("b2b_rsp_count", 32'(tags.size()), 32'd4);
      for (int t = 0; t < 4; t++) begin
         if (t < tags.size())
            chk($sformatf("b2b_tag%0d", t), 32'(tags[t]), 32'(t + 1));
         chk($sformatf("b2b_mem%0d", t), mem[64 + t], 32'hA000 + 32'(t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, default 8192, number of 32-bit words in the attached random_access_memory.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  1  transfer request present.
REQ-005 req_ready  output  1  unit idle, can accept a request.
REQ-006 req_load  input  1  1 = LDR (load), 0 = STR (store).
REQ-007 req_byte  input  1  1 = byte transfer, 0 = word transfer.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data; byte stores use bits [7:0].
REQ-010 req_rd  input  4  destination register tag, returned unchanged.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  load result; 0 for stores and faults.
REQ-013 rsp_rd  output  4  tag of the completing request.
REQ-014 rsp_fault  output  1  request rejected (misaligned or out of range).
REQ-015 ram_a  output  32  RAM word index.
REQ-016 ram_din  output  32  RAM write data.
REQ-017 ram_rw  output  1  RAM write strobe (1 = write).
REQ-018 ram_dout  input  32  RAM read data, valid one clock after the address is sampled.

Function
REQ-019 All outputs SHALL be registered. The request is accepted on edge E when req_valid and req_ready are both 1.
REQ-020 req_ready SHALL be 1 only in IDLE and SHALL fall on edge E. There is no response backpressure.
REQ-021 FSM states SHALL be IDLE, READ, WAIT, WRITE and RESP. RESP lasts exactly one cycle and then returns to IDLE.
REQ-022 Word index SHALL be req_addr[31:2]. Byte lane SHALL be req_addr[1:0], little-endian (lane n = bits 8n+7:8n).
REQ-023 Fault: a word request with addr[1:0] != 0, or a word index >= MEM_WORDS, SHALL go IDLE -> RESP. It makes no RAM access, sets rsp_fault=1 and rsp_rdata=0, and rsp_valid is high in the cycle after E.
REQ-024 Word load: IDLE -> READ (ram_a=index, ram_rw=0) -> WAIT -> RESP. At the WAIT -> RESP edge ram_dout SHALL be captured into rsp_rdata. rsp_valid is high in the cycle after E+2.
REQ-025 Byte load: same sequence and latency as a word load. rsp_rdata = selected lane, zero-extended.
REQ-026 Word store: IDLE -> WRITE (ram_a, ram_din=req_wdata, ram_rw=1) -> RESP. rsp_valid is high in the cycle after E+1.
REQ-027 Byte store: read-modify-write via READ -> WAIT -> WRITE -> RESP. Only the addressed lane of the read word is replaced by req_wdata[7:0]. rsp_valid is high in the cycle after E+3.
REQ-028 ram_rw SHALL be 1 for exactly one cycle per store (the WRITE state) and 0 otherwise. ram_a SHALL hold its value outside READ and WRITE.
REQ-029 Request fields SHALL be latched at E. Input changes after E have no effect.
REQ-030 rsp_rd SHALL equal the req_rd latched at E. rsp_rdata and rsp_fault SHALL be held until the next RESP.
REQ-031 req_valid seen outside IDLE SHALL be ignored and not queued.

Reset
REQ-032 On an rst edge: state=IDLE, req_ready=1, rsp_valid=0, rsp_fault=0, rsp_rdata=0, rsp_rd=0, ram_rw=0, ram_a=0, ram_din=0. Reset has priority over acceptance.
REQ-033 Reset mid-operation SHALL abandon the transfer with no response. A write already presented (ram_rw=1 before the edge) completes at that edge; no further RAM access is started.

Structure
REQ-034 Shared package limb_pkg SHALL hold the FSM state encoding and the lane-width and word-shift constants.
REQ-035 One combinational sub-module, byte_lane_unit, SHALL perform lane extract (load) and lane merge (store).

Verification
REQ-036 Word load, mem[4]=32'hDEADBEEF, addr=0x10, rd=3 -> rsp_valid in the cycle after E+2, rdata=32'hDEADBEEF, rsp_rd=3, fault=0.
REQ-037 Byte store, mem[2]=32'h11223344, addr=0x09, wdata=32'hAB -> mem[2]=32'h1122AB44; ram_rw high for exactly one cycle; rsp_valid in the cycle after E+3.
REQ-038 Byte load, mem[2]=32'h1122AB44, addr=0x0B -> rdata=32'h00000011.
REQ-039 Word load addr=0x06 and word store addr=0x8000 (index 8192) -> rsp_fault=1, rdata=0, no ram_rw pulse, rsp_valid in the cycle after E.
REQ-040 rst asserted during WAIT of a load -> no rsp_valid, req_ready=1 the cycle after reset, ram_rw never 1. A following word store of 32'h5 to addr 0 then completes normally.
REQ-041 req_valid held high for 10 cycles with back-to-back word stores -> each accepted only from IDLE, one ram_rw pulse per store, rsp_rd tags returned in order.
